// File: rtl/frame_deframer.sv
// Telemetry frame deframer: hunts a serial stream for 44-bit rotating markers, checks each
// following marker with a Hamming tolerance, and delivers the 12-bit payload words of every frame.
module frame_deframer #(
  parameter int WORDS_PER_FRAME = 256,
  parameter int MAX_ERR         = 3,
  parameter int CONFIRM         = 2,
  parameter int MISS_LIMIT      = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bitIn,
  input  logic        bitStrobe,
  output logic [11:0] outWord,
  output logic        outValid,
  output logic [8:0]  wordIdx,
  output logic [1:0]  markNum,
  output logic        frameStart,
  output logic        locked,
  output logic        syncErr
);

  localparam logic [30:0] MK_M = 31'b1111100110100100001010111011000;
  localparam logic [12:0] MK_B = 13'b1111100110101;
  localparam int CW = $clog2(CONFIRM + 1);
  localparam int MW = $clog2(MISS_LIMIT + 1);

  typedef enum logic [1:0] {SEARCH, DATA, CHECK} state_t;

  function automatic logic [43:0] marker(input logic [1:0] n);
    marker = {(n[0] ? ~MK_M : MK_M), (n[1] ? ~MK_B : MK_B)};
  endfunction

  function automatic logic [5:0] popcount44(input logic [43:0] v);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < 44; i++) cnt = cnt + 6'(v[i]);
    return cnt;
  endfunction

  state_t         state_q, state_d;
  // Only 43 bits of history are kept: the 44th bit of a marker is always the live bitIn.
  logic [42:0]    hist_q, hist_d;
  logic [10:0]    word_q, word_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [8:0]     word_cnt_q, word_cnt_d;
  logic [5:0]     mark_cnt_q, mark_cnt_d;
  logic [CW-1:0]  confirm_q, confirm_d, conf_inc;
  logic [MW-1:0]  miss_q, miss_d, miss_inc;
  logic [11:0]    out_word_q, out_word_d;
  logic           out_valid_q, out_valid_d;
  logic [8:0]     word_idx_q, word_idx_d;
  logic [1:0]     mark_num_q, mark_num_d;
  logic           frame_start_q, frame_start_d;
  logic           locked_q, locked_d;
  logic           sync_err_q, sync_err_d;
  logic [43:0]    nsr;
  logic [5:0]     dist_next;

  always_comb begin
    state_d       = state_q;
    hist_d        = hist_q;
    word_d        = word_q;
    bit_cnt_d     = bit_cnt_q;
    word_cnt_d    = word_cnt_q;
    mark_cnt_d    = mark_cnt_q;
    confirm_d     = confirm_q;
    miss_d        = miss_q;
    out_word_d    = out_word_q;
    word_idx_d    = word_idx_q;
    mark_num_d    = mark_num_q;
    locked_d      = locked_q;
    out_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    sync_err_d    = 1'b0;
    nsr           = {hist_q, bitIn};
    dist_next     = popcount44(nsr ^ marker(mark_num_q + 2'd1));
    conf_inc      = (confirm_q >= CW'(CONFIRM)) ? confirm_q : confirm_q + CW'(1);
    miss_inc      = miss_q + MW'(1);
    if (bitStrobe) begin
      hist_d = nsr[42:0];
      case (state_q)
        SEARCH: begin
          for (int n = 0; n < 4; n++) begin
            if (nsr == marker(2'(n))) begin
              state_d       = DATA;
              mark_num_d    = 2'(n);
              frame_start_d = 1'b1;
              bit_cnt_d     = '0;
              word_cnt_d    = '0;
              confirm_d     = CW'(1);
              miss_d        = '0;
            end
          end
        end
        DATA: begin
          word_d = {word_q[9:0], bitIn};
          if (bit_cnt_q == 4'd11) begin
            out_word_d  = {word_q, bitIn};
            word_idx_d  = word_cnt_q;
            out_valid_d = 1'b1;
            bit_cnt_d   = '0;
            if (word_cnt_q == 9'(WORDS_PER_FRAME - 1)) begin
              word_cnt_d = '0;
              mark_cnt_d = '0;
              state_d    = CHECK;
            end else begin
              word_cnt_d = word_cnt_q + 9'd1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        CHECK: begin
          if (mark_cnt_q == 6'd43) begin
            bit_cnt_d  = '0;
            word_cnt_d = '0;
            if (dist_next <= 6'(MAX_ERR)) begin
              mark_num_d    = mark_num_q + 2'd1;
              frame_start_d = 1'b1;
              miss_d        = '0;
              confirm_d     = conf_inc;
              if (conf_inc >= CW'(CONFIRM)) locked_d = 1'b1;
              state_d = DATA;
            end else begin
              sync_err_d = 1'b1;
              confirm_d  = '0;
              miss_d     = miss_inc;
              if (miss_inc >= MW'(MISS_LIMIT)) begin
                locked_d = 1'b0;
                state_d  = SEARCH;
              end else begin
                // Flywheel: assume the marker was there and keep the frame timing.
                mark_num_d    = mark_num_q + 2'd1;
                frame_start_d = 1'b1;
                state_d       = DATA;
              end
            end
          end else begin
            mark_cnt_d = mark_cnt_q + 6'd1;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= SEARCH;
      hist_q        <= '0;
      word_q        <= '0;
      bit_cnt_q     <= '0;
      word_cnt_q    <= '0;
      mark_cnt_q    <= '0;
      confirm_q     <= '0;
      miss_q        <= '0;
      out_word_q    <= '0;
      out_valid_q   <= 1'b0;
      word_idx_q    <= '0;
      mark_num_q    <= '0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      hist_q        <= hist_d;
      word_q        <= word_d;
      bit_cnt_q     <= bit_cnt_d;
      word_cnt_q    <= word_cnt_d;
      mark_cnt_q    <= mark_cnt_d;
      confirm_q     <= confirm_d;
      miss_q        <= miss_d;
      out_word_q    <= out_word_d;
      out_valid_q   <= out_valid_d;
      word_idx_q    <= word_idx_d;
      mark_num_q    <= mark_num_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign outWord    = out_word_q;
  assign outValid   = out_valid_q;
  assign wordIdx    = word_idx_q;
  assign markNum    = mark_num_q;
  assign frameStart = frame_start_q;
  assign locked     = locked_q;
  assign syncErr    = sync_err_q;

endmodule
